reg_file_mp: RTL and testbench

//  Parametrised, clocked register file for the single-cycle core datapath. Next

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_read_port.sv | 33 +++
 rtl/reg_file_mp.sv | 102 ++++++++++
 tb/tb_reg_file_mp.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file (reg_file_mp).
package rf_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    localparam int RF_ZERO_ADDR = 0;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: applies the zero-register, clear-in-progress and
// (with RF_WRITE_BYPASS_EN) write-through forwarding rules on top of the array.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]                           addr,
    input  logic [rf_depth(ADDR_W)-1:0][DATA_W-1:0]     array,
    input  logic                                        init_busy,
`ifdef RF_WRITE_BYPASS_EN
    input  logic                                        we,
    input  logic [ADDR_W-1:0]                           wr_addr,
    input  logic [DATA_W-1:0]                           wr_data,
`endif
    output logic [DATA_W-1:0]                           data
);

    // Address zero never reaches the mux, so forwarding can never expose a write to r0.
    always_comb begin
        data = '0;
        if (!init_busy && addr != ADDR_W'(RF_ZERO_ADDR)) begin
`ifdef RF_WRITE_BYPASS_EN
            if (we && addr == wr_addr) data = wr_data;
            else                       data = array[addr];
`else
            data = array[addr];
`endif
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired r0 and a post-reset clear sequencer.
// Define RF_WRITE_BYPASS_EN to forward same-cycle writes to matching read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic                      init_busy,
    output logic                      wr_drop
);

    localparam int              DEPTH    = rf_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    rf_state_e                    state_q, state_d;
    logic [ADDR_W:0]              clr_idx_q, clr_idx_d;
    logic                         init_busy_q, init_busy_d;
    logic                         wr_drop_q, wr_drop_d;
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    logic                         mem_we;
    logic [ADDR_W-1:0]            mem_waddr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         wr_zero;

    assign wr_zero = (wr_addr == ADDR_W'(RF_ZERO_ADDR));

    // While clearing, the sequencer owns the single write path; user writes are dropped.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            RF_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q[ADDR_W-1:0];
                mem_wdata = '0;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = RF_RUN;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + (ADDR_W+1)'(1);
                end
            end
            RF_RUN:  mem_we = we && !wr_zero;
            default: state_d = RF_INIT;
        endcase
        init_busy_d = (state_d == RF_INIT);
        wr_drop_d   = we && (state_q == RF_INIT || wr_zero);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RF_INIT;
            clr_idx_q   <= '0;
            init_busy_q <= 1'b1;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            init_busy_q <= init_busy_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // The array has no reset term so contents stay untouched while rst is held.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign init_busy = init_busy_q;
    assign wr_drop   = wr_drop_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
            .array     (mem_q),
            .init_busy (init_busy_q),
`ifdef RF_WRITE_BYPASS_EN
            .we        (we && state_q == RF_RUN),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
`endif
            .data      (rd_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default 32x32, two read ports).
module tb_reg_file_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     init_busy;
    logic                     wr_drop;
    logic [DATA_W-1:0]        rd0, rd1;

    int checks   = 0;
    int failures = 0;

    assign rd0 = rd_data[DATA_W-1:0];
    assign rd1 = rd_data[2*DATA_W-1:DATA_W];

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .init_busy (init_busy),
        .wr_drop   (wr_drop)
    );

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Leaves the bench on a falling edge with we deasserted, one edge after the write.
    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we      = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        we      = 1'b0;
    endtask

    // Counts falling-edge samples with init_busy high, bounded against a stuck sequencer.
    task automatic count_busy(output int cyc);
        cyc = 0;
        while (init_busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        int bad;
        for (int i = 1; i < DEPTH; i++) write_reg(ADDR_W'(i), 32'hA500_0000 | i);
        @(negedge clk);
        rst = 1'b1;
        set_rd(5'd31, 5'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (init_busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_busy: got %b expected 1", init_busy);
            end
            checks++;
            if (wr_drop !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_drop: got %b expected 0", wr_drop);
            end
            checks++;
            if (rd_data !== '0) begin
                failures++;
                $display("[TB] FAIL reset_read: got %h expected 0", rd_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cyc = 0;
        bad = 0;
        while (init_busy === 1'b1 && cyc < 200) begin
            if (rd_data !== '0) bad++;
            set_rd(ADDR_W'(cyc), ADDR_W'(31 - cyc));
            cyc++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (cyc !== 32) begin
            failures++;
            $display("[TB] FAIL init_len: got %0d cycles expected 32", cyc);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL init_reads: got %0d nonzero reads expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
            #1;
            if (rd_data !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL cleared_entries: got %0d nonzero expected 0", bad);
        end
    endtask

    task automatic test_basic_rw();
        write_reg(5'd5, 32'hDEAD_BEEF);
        set_rd(5'd5, 5'd5);
        #1;
        checks++;
        if (rd0 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL basic_rd0: got %h expected deadbeef", rd0);
        end
        checks++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL basic_rd1: got %h expected deadbeef", rd1);
        end
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_drop: got %b expected 0", wr_drop);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h1234;
        set_rd(5'd0, 5'd5);
        #1;
        checks++;
        if (rd0 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL zero_same_cycle: got %h expected 0", rd0);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (wr_drop !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_drop: got %b expected 1", wr_drop);
        end
        checks++;
        if (rd0 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL zero_read: got %h expected 0", rd0);
        end
        checks++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL zero_other_port: got %h expected deadbeef", rd1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_drop_clear: got %b expected 0", wr_drop);
        end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] exp_same;
`ifdef RF_WRITE_BYPASS_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        write_reg(5'd9, 32'h11);
        we      = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h22;
        set_rd(5'd9, 5'd5);
        #1;
        checks++;
        if (rd0 !== exp_same) begin
            failures++;
            $display("[TB] FAIL same_cycle_rd: got %h expected %h", rd0, exp_same);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rd0 !== 32'h22) begin
            failures++;
            $display("[TB] FAIL next_cycle_rd: got %h expected 22", rd0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we      = 1'b1;
        wr_addr = 5'd1;
        wr_data = 32'h0000_0101;
        @(negedge clk);
        wr_addr = 5'd31;
        wr_data = 32'hFFFF_0031;
        @(negedge clk);
        we = 1'b0;
        set_rd(5'd1, 5'd31);
        #1;
        checks++;
        if (rd0 !== 32'h0000_0101) begin
            failures++;
            $display("[TB] FAIL b2b_r1: got %h expected 00000101", rd0);
        end
        checks++;
        if (rd1 !== 32'hFFFF_0031) begin
            failures++;
            $display("[TB] FAIL b2b_r31: got %h expected ffff0031", rd1);
        end
    endtask

    task automatic test_init_write();
        int cyc;
        write_reg(5'd7, 32'h7777_7777);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        we      = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hAA;
        #1;
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL init_write_busy: got %b expected 1", init_busy);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (wr_drop !== 1'b1) begin
            failures++;
            $display("[TB] FAIL init_write_drop: got %b expected 1", wr_drop);
        end
        @(negedge clk);
        #1;
        checks++;
        if (wr_drop !== 1'b0) begin
            failures++;
            $display("[TB] FAIL init_write_drop_clear: got %b expected 0", wr_drop);
        end
        count_busy(cyc);
        checks++;
        if (init_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL init_write_done: got %b expected 0", init_busy);
        end
        set_rd(5'd7, 5'd7);
        #1;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("[TB] FAIL init_write_r7: got %h expected 0", rd_data);
        end
    endtask

    task automatic test_reset_mid_init();
        int cyc;
        int bad;
        write_reg(5'd3, 32'h0303_0303);
        write_reg(5'd20, 32'h2020_2020);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy(cyc);
        checks++;
        if (cyc !== 32) begin
            failures++;
            $display("[TB] FAIL restart_len: got %0d cycles expected 32", cyc);
        end
        set_rd(5'd20, 5'd3);
        #1;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("[TB] FAIL restart_r20_r3: got %h expected 0", rd_data);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(ADDR_W'(i), ADDR_W'(i));
            #1;
            if (rd_data !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL restart_entries: got %0d nonzero expected 0", bad);
        end
    endtask

    initial begin
        int cyc;
        rst     = 1'b1;
        we      = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        count_busy(cyc);
        checks++;
        if (init_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bringup_done: got %b expected 0", init_busy);
        end
        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_same_cycle();
        test_back_to_back();
        test_init_write();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
